// File: rtl/diagonal_matrix_streamer_pkg.sv
// Shared types and helpers for the diagonal matrix streamer.
// Defines the FSM state encoding and the row-index width rule.
package diag_stream_pkg;

  typedef enum logic {
    DS_IDLE,
    DS_STREAM
  } ds_state_t;

  // A single-row matrix still needs a 1-bit index.
  function automatic int idx_width(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/diagonal_matrix_streamer_row_select.sv
// Expands a scalar and a row index into one row of a diagonal matrix.
// The value lands in the column equal to the row index; every other column is zero.
module diagonal_row_select #(
  parameter int BIT_WIDTH = 4,
  parameter int COLS      = 8,
  parameter int IDX_W     = 3
) (
  input  logic [BIT_WIDTH-1:0] value,
  input  logic [IDX_W-1:0]     row_idx,
  output logic [BIT_WIDTH-1:0] row [COLS]
);

  // Indices past the last column match nothing, giving all-zero rows.
  always_comb begin
    for (int j = 0; j < COLS; j++) begin
      row[j] = (int'(row_idx) == j) ? value : '0;
    end
  end

endmodule

// File: rtl/diagonal_matrix_streamer.sv
// Streams a ROWS x COLS diagonal matrix built from one accepted scalar, one row per beat.
// A new scalar is taken on the last-row beat so matrices can run back to back.
module diagonal_matrix_streamer
  import diag_stream_pkg::*;
#(
  parameter int  BIT_WIDTH = 4,
  parameter int  ROWS      = 8,
  parameter int  COLS      = 8,
  localparam int IDX_W     = idx_width(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_row [COLS],
  output logic [IDX_W-1:0]     out_row_idx,
  output logic                 out_last
);

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

  ds_state_t            state;
  logic [BIT_WIDTH-1:0] value_q;
  logic [IDX_W-1:0]     row_q;
  logic                 acc;
  logic                 beat;

  assign out_valid   = (state == DS_STREAM);
  assign out_row_idx = row_q;
  assign out_last    = out_valid && (row_q == LAST_ROW);
  // Open for a new scalar while the final row is being taken.
  assign in_ready    = (state == DS_IDLE) || (out_last && out_ready);
  assign acc         = in_valid && in_ready;
  assign beat        = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DS_IDLE;
      value_q <= '0;
      row_q   <= '0;
    end else if (acc) begin
      state   <= DS_STREAM;
      value_q <= in;
      row_q   <= '0;
    end else if (beat) begin
      if (row_q != LAST_ROW) begin
        row_q <= row_q + IDX_W'(1);
      end else begin
        state <= DS_IDLE;
      end
    end
  end

  diagonal_row_select #(
    .BIT_WIDTH (BIT_WIDTH),
    .COLS      (COLS),
    .IDX_W     (IDX_W)
  ) u_row_select (
    .value   (value_q),
    .row_idx (row_q),
    .row     (out_row)
  );

endmodule

// File: tb/tb_diagonal_matrix_streamer.sv
// Bench for diagonal_matrix_streamer: 8x8, 4x2 and 2x4 instances on shared stimulus,
// checked each cycle against a rows-remaining model plus directed literal checks.
module tb_diagonal_matrix_streamer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] din = 4'h0;
  logic       out_ready = 1'b1;

  logic       rdy0, rdy1, rdy2, v0, v1, v2, l0, l1, l2;
  logic [3:0] r0 [8];
  logic [3:0] r1 [2];
  logic [3:0] r2 [4];
  logic [2:0] i0;
  logic [1:0] i1;
  logic [0:0] i2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  diagonal_matrix_streamer #(.BIT_WIDTH(4), .ROWS(8), .COLS(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in(din),
    .out_valid(v0), .out_ready(out_ready), .out_row(r0), .out_row_idx(i0), .out_last(l0));

  diagonal_matrix_streamer #(.BIT_WIDTH(4), .ROWS(4), .COLS(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in(din),
    .out_valid(v1), .out_ready(out_ready), .out_row(r1), .out_row_idx(i1), .out_last(l1));

  diagonal_matrix_streamer #(.BIT_WIDTH(4), .ROWS(2), .COLS(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in(din),
    .out_valid(v2), .out_ready(out_ready), .out_row(r2), .out_row_idx(i2), .out_last(l2));

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int g_valid(input int i);
    case (i)
      0: return int'(v0);
      1: return int'(v1);
      default: return int'(v2);
    endcase
  endfunction

  function automatic int g_ready(input int i);
    case (i)
      0: return int'(rdy0);
      1: return int'(rdy1);
      default: return int'(rdy2);
    endcase
  endfunction

  function automatic int g_last(input int i);
    case (i)
      0: return int'(l0);
      1: return int'(l1);
      default: return int'(l2);
    endcase
  endfunction

  function automatic int g_idx(input int i);
    case (i)
      0: return int'(i0);
      1: return int'(i1);
      default: return int'(i2);
    endcase
  endfunction

  function automatic int g_elem(input int i, input int j);
    case (i)
      0: return int'(r0[j]);
      1: return int'(r1[j]);
      default: return int'(r2[j]);
    endcase
  endfunction

  // Model: each accepted scalar owes ROWS rows; track how many are still owed.
  int nrows [3] = '{8, 4, 2};
  int ncols [3] = '{8, 2, 4};
  int left  [3] = '{0, 0, 0};
  int val   [3] = '{0, 0, 0};

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        int  row_no;
        int  exp_rdy;
        bit  acc_m;
        row_no  = nrows[i] - left[i];
        exp_rdy = (left[i] == 0 || (left[i] == 1 && out_ready)) ? 1 : 0;
        chk($sformatf("m%0d_out_valid", i), g_valid(i), (left[i] > 0) ? 1 : 0);
        chk($sformatf("m%0d_in_ready", i), g_ready(i), exp_rdy);
        chk($sformatf("m%0d_out_last", i), g_last(i), (left[i] == 1) ? 1 : 0);
        if (left[i] > 0) begin
          chk($sformatf("m%0d_row_idx", i), g_idx(i), row_no);
          for (int j = 0; j < ncols[i]; j++) begin
            chk($sformatf("m%0d_row%0d_col%0d", i, row_no, j), g_elem(i, j),
                (j == row_no) ? val[i] : 0);
          end
        end
        acc_m = in_valid && (exp_rdy == 1);
        if (rst) begin
          left[i] = 0;
          val[i]  = 0;
        end else if (acc_m) begin
          left[i] = nrows[i];
          val[i]  = int'(din);
        end else if (left[i] > 0 && out_ready) begin
          left[i] = left[i] - 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((v0 || v1 || v2) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    int vcnt;
    int rcnt;

    // Reset with a scalar offered: nothing may be taken.
    rst = 1'b1; in_valid = 1'b1; din = 4'hA; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", int'(v0), 0);
    chk("rst_in_ready", int'(rdy0), 1);
    chk("rst_out_last", int'(l0), 0);
    chk("rst_row_idx", int'(i0), 0);
    for (int j = 0; j < 8; j++) chk($sformatf("rst_row_col%0d", j), int'(r0[j]), 0);
    rst = 1'b0;
    step();
    in_valid = 1'b0;
    chk("first_acc_valid", int'(v0), 1);
    chk("first_acc_row0", int'(r0[0]), 10);
    wait_idle();

    // Single 8x8 matrix of 5.
    din = 4'h5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int r = 0; r < 8; r++) begin
      chk($sformatf("single_idx_r%0d", r), int'(i0), r);
      chk($sformatf("single_diag_r%0d", r), int'(r0[r]), 5);
      chk($sformatf("single_last_r%0d", r), int'(l0), (r == 7) ? 1 : 0);
      step();
    end
    chk("single_end_valid", int'(v0), 0);
    chk("single_end_ready", int'(rdy0), 1);
    wait_idle();

    // Backpressure at row 3.
    din = 4'h7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall_idx_%0d", k), int'(i0), 3);
      chk($sformatf("stall_diag_%0d", k), int'(r0[3]), 7);
      chk($sformatf("stall_ready_%0d", k), int'(rdy0), 0);
      step();
    end
    out_ready = 1'b1;
    for (int r = 3; r < 8; r++) begin
      chk($sformatf("resume_idx_r%0d", r), int'(i0), r);
      step();
    end
    wait_idle();

    // Back-to-back matrices 3 then C.
    din = 4'h3; in_valid = 1'b1;
    step();
    din = 4'hC;
    vcnt = 0;
    rcnt = 0;
    for (int c = 0; c < 16; c++) begin
      if (v0) vcnt++;
      if (rdy0) rcnt++;
      if (c == 8) begin
        chk("b2b_second_row0", int'(r0[0]), 12);
        chk("b2b_second_idx", int'(i0), 0);
        in_valid = 1'b0;
      end
      step();
    end
    chk("b2b_valid_cycles", vcnt, 16);
    chk("b2b_ready_pulses", rcnt, 2);
    wait_idle();

    // Non-square shapes: 4x2 and 2x4.
    din = 4'h9; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("r4c2_col0_r%0d", r), int'(r1[0]), (r == 0) ? 9 : 0);
      chk($sformatf("r4c2_col1_r%0d", r), int'(r1[1]), (r == 1) ? 9 : 0);
      if (r < 2) begin
        chk($sformatf("r2c4_col2_r%0d", r), int'(r2[2]), 0);
        chk($sformatf("r2c4_col3_r%0d", r), int'(r2[3]), 0);
        chk($sformatf("r2c4_diag_r%0d", r), int'(r2[r]), 9);
      end
      step();
    end
    wait_idle();

    // Reset during row 5.
    din = 4'h6; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("midrst_pre_idx", int'(i0), 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_valid", int'(v0), 0);
    chk("midrst_ready", int'(rdy0), 1);
    din = 4'h1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("midrst_new_idx", int'(i0), 0);
    chk("midrst_new_row0", int'(r0[0]), 1);
    wait_idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
